mining_job_sequencer: RTL

//  Sequences one mining job at a time into the SHA design core.
//  - Pulses start_found, then streams 8 midstate words and 16 header words from a host word stream.
//  - Waits for a solution or a timeout, acknowledges the core's sol_claim with sol_response.
//  - Reports the golden nonce or timeout on a valid/ack result port.

---
 rtl/mining_job_sequencer_if.sv | 46 ++++
 rtl/mining_job_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mining_job_sequencer_if.sv
// Bundle of every non-clock signal of the mining job sequencer.
//
// Handshakes:
//   Job words move on job_valid/job_ready. A word is consumed on every cycle
//   where both are 1; the source must hold job_data steady until then.
//   Results move on res_valid/res_ack. res_nonce/res_timeout are stable while
//   res_valid=1 and are retired on the cycle where res_ack=1.
//
// Modports:
//   master : host word source, core and result consumer (the environment)
//   slave  : the sequencer itself
interface mining_job_sequencer_if #(
    parameter int TIMEOUT_W = 32
);
    // host job word stream
    logic                 job_valid;
    logic [31:0]          job_data;
    logic                 job_ready;
    logic                 abort;
    logic [TIMEOUT_W-1:0] timeout_cycles;
    // design core side
    logic                 start_found;
    logic                 shift_in_en;
    logic [31:0]          core_data;
    logic                 sol_claim;
    logic [31:0]          nonce_in;
    logic                 sol_response;
    // result port
    logic                 res_valid;
    logic [31:0]          res_nonce;
    logic                 res_timeout;
    logic                 res_ack;
    logic                 busy;

    modport master (
        output job_valid, job_data, abort, timeout_cycles, sol_claim, nonce_in, res_ack,
        input  job_ready, start_found, shift_in_en, core_data, sol_response,
               res_valid, res_nonce, res_timeout, busy
    );

    modport slave (
        input  job_valid, job_data, abort, timeout_cycles, sol_claim, nonce_in, res_ack,
        output job_ready, start_found, shift_in_en, core_data, sol_response,
               res_valid, res_nonce, res_timeout, busy
    );
endinterface

// File: rtl/mining_job_sequencer.sv
// Sequences one mining job at a time from a host word stream into the SHA
// design core: pulses start_found, streams MID_WORDS midstate words and
// HEAD_WORDS header words, waits for a solution claim or a timeout,
// acknowledges the claim and reports the golden nonce (or a timeout) on a
// valid/ack result port.
//
// Ports:
//   clk        : system clock, rising edge
//   n_rst      : asynchronous active-low reset
//   bus        : mining_job_sequencer_if.slave (job stream, core strobes, result port)
//   state_dbg  : current FSM state, for observation only
module mining_job_sequencer #(
    parameter int TIMEOUT_W  = 32,
    parameter int MID_WORDS  = 8,
    parameter int HEAD_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    mining_job_sequencer_if.slave bus,
    output logic [2:0]            state_dbg
);

    localparam int MAX_WORDS = (HEAD_WORDS > MID_WORDS) ? HEAD_WORDS : MID_WORDS;
    localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_LOAD_MID  = 3'd2,
        ST_LOAD_HEAD = 3'd3,
        ST_SOLVE     = 3'd4,
        ST_RESPOND   = 3'd5,
        ST_REPORT    = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [31:0]          res_nonce_q, res_nonce_d;
    logic                 res_timeout_q, res_timeout_d;
    // Strobes are registered from the next state so they line up exactly
    // with the state they belong to and never glitch.
    logic                 job_ready_q, job_ready_d;
    logic                 start_found_q, start_found_d;
    logic                 sol_response_q, sol_response_d;
    logic                 res_valid_q, res_valid_d;
    logic                 busy_q, busy_d;

    logic                 accept;

    assign accept = bus.job_valid & job_ready_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        res_nonce_d   = res_nonce_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            ST_IDLE: begin
                // Only notices the job; the first word stays on the bus.
                if (bus.job_valid) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_LOAD_MID;
                cnt_d   = '0;
            end
            ST_LOAD_MID: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(MID_WORDS - 1)) begin
                        state_d = ST_LOAD_HEAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD_HEAD: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(HEAD_WORDS - 1)) begin
                        state_d = ST_SOLVE;
                        cnt_d   = '0;
                        timer_d = bus.timeout_cycles;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SOLVE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMEOUT_W'(1);
                end
                // Claim is checked first so it wins over a coincident expiry.
                if (bus.sol_claim) begin
                    res_nonce_d   = bus.nonce_in;
                    res_timeout_d = 1'b0;
                    state_d       = ST_RESPOND;
                end else if ((timer_q == TIMEOUT_W'(1)) && (bus.timeout_cycles != '0)) begin
                    res_nonce_d   = '0;
                    res_timeout_d = 1'b1;
                    state_d       = ST_REPORT;
                end
            end
            ST_RESPOND: begin
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (bus.res_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort discards everything, including a claim seen this same cycle.
        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            res_nonce_d   = res_nonce_q;
            res_timeout_d = res_timeout_q;
        end

        // The timer only has meaning while solving.
        if (state_d != ST_SOLVE) begin
            timer_d = '0;
        end

        job_ready_d    = (state_d == ST_LOAD_MID) || (state_d == ST_LOAD_HEAD);
        start_found_d  = (state_d == ST_START);
        sol_response_d = (state_d == ST_RESPOND);
        res_valid_d    = (state_d == ST_REPORT);
        busy_d         = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            timer_q        <= '0;
            res_nonce_q    <= '0;
            res_timeout_q  <= 1'b0;
            job_ready_q    <= 1'b0;
            start_found_q  <= 1'b0;
            sol_response_q <= 1'b0;
            res_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            res_nonce_q    <= res_nonce_d;
            res_timeout_q  <= res_timeout_d;
            job_ready_q    <= job_ready_d;
            start_found_q  <= start_found_d;
            sol_response_q <= sol_response_d;
            res_valid_q    <= res_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.job_ready    = job_ready_q;
    assign bus.shift_in_en  = bus.job_valid & job_ready_q;
    assign bus.core_data    = bus.job_data;
    assign bus.start_found  = start_found_q;
    assign bus.sol_response = sol_response_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_nonce    = res_nonce_q;
    assign bus.res_timeout  = res_timeout_q;
    assign bus.busy         = busy_q;
    assign state_dbg        = state_q;

endmodule
